// File: rtl/axi4lite_slave_regs.sv
// AXI4-Lite responder over a word-addressed register file; write and read FSMs run concurrently.
// Define AXI_SLV_ERR_EN to answer out-of-window accesses with SLVERR; otherwise they complete as OKAY.
module axi4lite_slave_regs #(
    parameter int                    ADDR_WIDTH = 32,
    parameter int                    DATA_WIDTH = 32,
    parameter logic [ADDR_WIDTH-1:0] BASE_ADDR  = 32'h0000_0600,
    parameter int                    NUM_REGS   = 16
) (
    input  logic                      ACLK,
    input  logic                      ARESETN,

    input  logic [ADDR_WIDTH-1:0]     AWADDR,
    input  logic [2:0]                AWPROT,
    input  logic                      AWVALID,
    output logic                      AWREADY,

    input  logic [DATA_WIDTH-1:0]     WDATA,
    input  logic [DATA_WIDTH/8-1:0]   WSTRB,
    input  logic                      WVALID,
    output logic                      WREADY,

    output logic [1:0]                BRESP,
    output logic                      BVALID,
    input  logic                      BREADY,

    input  logic [ADDR_WIDTH-1:0]     ARADDR,
    input  logic [2:0]                ARPROT,
    input  logic                      ARVALID,
    output logic                      ARREADY,

    output logic [DATA_WIDTH-1:0]     RDATA,
    output logic [1:0]                RRESP,
    output logic                      RVALID,
    input  logic                      RREADY
);
    localparam int STRB_WIDTH = DATA_WIDTH / 8;
    localparam int IDX_WIDTH  = (NUM_REGS > 1) ? $clog2(NUM_REGS) : 1;
    localparam int LIM_WIDTH  = ADDR_WIDTH + 1;
    localparam logic [LIM_WIDTH-1:0] WIN_LO = {1'b0, BASE_ADDR};
    localparam logic [LIM_WIDTH-1:0] WIN_HI = WIN_LO + LIM_WIDTH'(4 * NUM_REGS);

    localparam logic [1:0] RESP_OKAY = 2'b00;
`ifdef AXI_SLV_ERR_EN
    localparam logic [1:0] RESP_OOR  = 2'b10;
`else
    localparam logic [1:0] RESP_OOR  = 2'b00;
`endif

    localparam logic [0:0] W_IDLE = 1'b0;
    localparam logic [0:0] W_RESP = 1'b1;
    localparam logic [0:0] R_IDLE = 1'b0;
    localparam logic [0:0] R_DATA = 1'b1;

    logic [DATA_WIDTH-1:0] regs [NUM_REGS];

    logic [0:0]            w_state;
    logic [0:0]            r_state;
    logic                  aw_held;
    logic                  w_held;
    logic [ADDR_WIDTH-1:0] aw_addr_q;
    logic [DATA_WIDTH-1:0] w_data_q;
    logic [STRB_WIDTH-1:0] w_strb_q;

    logic                  aw_hs;
    logic                  w_hs;
    logic                  b_hs;
    logic                  ar_hs;
    logic                  r_hs;
    logic                  wr_commit;
    logic [ADDR_WIDTH-1:0] wr_addr;
    logic [DATA_WIDTH-1:0] wr_data;
    logic [STRB_WIDTH-1:0] wr_strb;
    logic [ADDR_WIDTH-1:0] wr_off;
    logic [ADDR_WIDTH-1:0] rd_off;
    logic [IDX_WIDTH-1:0]  wr_idx;
    logic [IDX_WIDTH-1:0]  rd_idx;
    logic                  wr_in_range;
    logic                  rd_in_range;
    logic                  unused_bits;

    function automatic logic in_window(input logic [ADDR_WIDTH-1:0] addr);
        return ({1'b0, addr} >= WIN_LO) && ({1'b0, addr} < WIN_HI);
    endfunction

    assign aw_hs = AWVALID && AWREADY;
    assign w_hs  = WVALID && WREADY;
    assign b_hs  = BVALID && BREADY;
    assign ar_hs = ARVALID && ARREADY;
    assign r_hs  = RVALID && RREADY;

    // A channel captured on an earlier edge is served from its latch, otherwise straight from the bus.
    assign wr_addr = aw_held ? aw_addr_q : AWADDR;
    assign wr_data = w_held  ? w_data_q  : WDATA;
    assign wr_strb = w_held  ? w_strb_q  : WSTRB;

    assign wr_commit = (w_state == W_IDLE) && (aw_held || aw_hs) && (w_held || w_hs);

    assign wr_in_range = in_window(wr_addr);
    assign rd_in_range = in_window(ARADDR);
    assign wr_off      = wr_addr - BASE_ADDR;
    assign rd_off      = ARADDR - BASE_ADDR;
    assign wr_idx      = wr_off[IDX_WIDTH+1:2];
    assign rd_idx      = rd_off[IDX_WIDTH+1:2];

    assign unused_bits = &{1'b0, AWPROT, ARPROT, wr_off, rd_off};

    always_ff @(posedge ACLK) begin
        if (!ARESETN) begin
            w_state   <= W_IDLE;
            aw_held   <= 1'b0;
            w_held    <= 1'b0;
            aw_addr_q <= '0;
            w_data_q  <= '0;
            w_strb_q  <= '0;
            AWREADY   <= 1'b0;
            WREADY    <= 1'b0;
            BVALID    <= 1'b0;
            BRESP     <= RESP_OKAY;
        end else begin
            case (w_state)
                W_IDLE: begin
                    if (wr_commit) begin
                        w_state <= W_RESP;
                        aw_held <= 1'b0;
                        w_held  <= 1'b0;
                        AWREADY <= 1'b0;
                        WREADY  <= 1'b0;
                        BVALID  <= 1'b1;
                        BRESP   <= wr_in_range ? RESP_OKAY : RESP_OOR;
                    end else begin
                        if (aw_hs) begin
                            aw_held   <= 1'b1;
                            aw_addr_q <= AWADDR;
                        end
                        if (w_hs) begin
                            w_held   <= 1'b1;
                            w_data_q <= WDATA;
                            w_strb_q <= WSTRB;
                        end
                        AWREADY <= !(aw_held || aw_hs);
                        WREADY  <= !(w_held || w_hs);
                    end
                end
                W_RESP: begin
                    if (b_hs) begin
                        w_state <= W_IDLE;
                        BVALID  <= 1'b0;
                        AWREADY <= 1'b1;
                        WREADY  <= 1'b1;
                    end
                end
                default: w_state <= W_IDLE;
            endcase
        end
    end

    always_ff @(posedge ACLK) begin
        if (!ARESETN) begin
            for (int i = 0; i < NUM_REGS; i++) begin
                regs[i] <= '0;
            end
        end else if (wr_commit && wr_in_range) begin
            for (int b = 0; b < STRB_WIDTH; b++) begin
                if (wr_strb[b]) begin
                    regs[wr_idx][8*b +: 8] <= wr_data[8*b +: 8];
                end
            end
        end
    end

    // Read samples the array before any same-edge commit lands, so it sees the old value.
    always_ff @(posedge ACLK) begin
        if (!ARESETN) begin
            r_state <= R_IDLE;
            ARREADY <= 1'b0;
            RVALID  <= 1'b0;
            RDATA   <= '0;
            RRESP   <= RESP_OKAY;
        end else begin
            case (r_state)
                R_IDLE: begin
                    if (ar_hs) begin
                        r_state <= R_DATA;
                        ARREADY <= 1'b0;
                        RVALID  <= 1'b1;
                        if (rd_in_range) begin
                            RDATA <= regs[rd_idx];
                            RRESP <= RESP_OKAY;
                        end else begin
                            RDATA <= '0;
                            RRESP <= RESP_OOR;
                        end
                    end else begin
                        ARREADY <= 1'b1;
                    end
                end
                R_DATA: begin
                    if (r_hs) begin
                        r_state <= R_IDLE;
                        RVALID  <= 1'b0;
                        ARREADY <= 1'b1;
                    end
                end
                default: r_state <= R_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_axi4lite_slave_regs.sv
// Self-checking bench for axi4lite_slave_regs: directed scenarios plus random traffic against a word-array model.
module tb_axi4lite_slave_regs;
    logic        ACLK = 1'b0;
    logic        ARESETN;
    logic [31:0] AWADDR;
    logic [2:0]  AWPROT;
    logic        AWVALID;
    logic        AWREADY;
    logic [31:0] WDATA;
    logic [3:0]  WSTRB;
    logic        WVALID;
    logic        WREADY;
    logic [1:0]  BRESP;
    logic        BVALID;
    logic        BREADY;
    logic [31:0] ARADDR;
    logic [2:0]  ARPROT;
    logic        ARVALID;
    logic        ARREADY;
    logic [31:0] RDATA;
    logic [1:0]  RRESP;
    logic        RVALID;
    logic        RREADY;

    int errors = 0;
    int checks = 0;

`ifdef AXI_SLV_ERR_EN
    localparam logic [1:0] EXP_OOR = 2'b10;
`else
    localparam logic [1:0] EXP_OOR = 2'b00;
`endif

    logic [31:0] model [16];

    always #5 ACLK = ~ACLK;

    axi4lite_slave_regs dut (
        .ACLK(ACLK), .ARESETN(ARESETN),
        .AWADDR(AWADDR), .AWPROT(AWPROT), .AWVALID(AWVALID), .AWREADY(AWREADY),
        .WDATA(WDATA), .WSTRB(WSTRB), .WVALID(WVALID), .WREADY(WREADY),
        .BRESP(BRESP), .BVALID(BVALID), .BREADY(BREADY),
        .ARADDR(ARADDR), .ARPROT(ARPROT), .ARVALID(ARVALID), .ARREADY(ARREADY),
        .RDATA(RDATA), .RRESP(RRESP), .RVALID(RVALID), .RREADY(RREADY)
    );

    function automatic bit in_win(input logic [31:0] a);
        return (a >= 32'h600) && (a < 32'h640);
    endfunction

    function automatic logic [3:0] widx(input logic [31:0] a);
        logic [31:0] off;
        off = a - 32'h600;
        return off[5:2];
    endfunction

    function automatic logic [1:0] exp_resp(input logic [31:0] a);
        return in_win(a) ? 2'b00 : EXP_OOR;
    endfunction

    function automatic logic [31:0] model_read(input logic [31:0] a);
        return in_win(a) ? model[widx(a)] : 32'h0;
    endfunction

    task automatic model_write(input logic [31:0] a, input logic [31:0] d, input logic [3:0] s);
        if (in_win(a)) begin
            for (int b = 0; b < 4; b++) begin
                if (s[b]) model[widx(a)][8*b +: 8] = d[8*b +: 8];
            end
        end
    endtask

    task automatic model_clear();
        for (int i = 0; i < 16; i++) model[i] = 32'h0;
    endtask

    function automatic logic [31:0] rand_addr();
        int sel;
        sel = $urandom_range(0, 19);
        if (sel < 16) return 32'h600 + $urandom_range(0, 63);
        else if (sel == 16) return 32'h5F0 + $urandom_range(0, 15);
        else if (sel == 17) return 32'h640 + $urandom_range(0, 15);
        else return $urandom;
    endfunction

    // Presents AW and W after independent delays; returns on the negedge after the commit edge.
    task automatic send_aw_w(input logic [31:0] addr, input logic [31:0] data, input logic [3:0] strb,
                             input int aw_dly, input int w_dly);
        int cyc;
        bit aw_done;
        bit w_done;
        cyc = 0; aw_done = 0; w_done = 0;
        AWADDR = addr; WDATA = data; WSTRB = strb; AWPROT = 3'($urandom);
        while (!(aw_done && w_done)) begin
            @(negedge ACLK);
            if (cyc >= 60) begin
                checks++; errors++;
                $display("FAIL aw_w_timeout: got no AW/W handshake after %0d cycles, required within 60", cyc);
                break;
            end
            AWVALID = !aw_done && (cyc >= aw_dly);
            WVALID  = !w_done && (cyc >= w_dly);
            if (AWVALID && AWREADY) aw_done = 1;
            if (WVALID && WREADY) w_done = 1;
            cyc++;
        end
        @(negedge ACLK);
        AWVALID = 0; WVALID = 0;
    endtask

    task automatic wait_b(input int bdly, output logic [1:0] resp, output int lat);
        lat = 0;
        while (!BVALID && lat < 50) begin
            @(negedge ACLK);
            lat++;
        end
        if (!BVALID) begin
            checks++; errors++;
            $display("FAIL b_timeout: got BVALID=0 after %0d cycles, required 1", lat);
        end
        resp = BRESP;
        repeat (bdly) @(negedge ACLK);
        BREADY = 1;
        @(negedge ACLK);
        BREADY = 0;
    endtask

    task automatic read_reg(input logic [31:0] addr, input int rdly,
                            output logic [31:0] data, output logic [1:0] resp, output int lat);
        int n;
        @(negedge ACLK);
        ARADDR = addr; ARVALID = 1; ARPROT = 3'($urandom);
        n = 0;
        while (!ARREADY && n < 50) begin
            @(negedge ACLK);
            n++;
        end
        if (!ARREADY) begin
            checks++; errors++;
            $display("FAIL ar_timeout: got ARREADY=0 after %0d cycles, required 1", n);
        end
        @(negedge ACLK);
        ARVALID = 0;
        lat = 0;
        while (!RVALID && lat < 50) begin
            @(negedge ACLK);
            lat++;
        end
        if (!RVALID) begin
            checks++; errors++;
            $display("FAIL r_timeout: got RVALID=0 after %0d cycles, required 1", lat);
        end
        data = RDATA; resp = RRESP;
        repeat (rdly) @(negedge ACLK);
        RREADY = 1;
        @(negedge ACLK);
        RREADY = 0;
    endtask

    task automatic test_reset();
        ARESETN = 0;
        repeat (3) @(negedge ACLK);
        checks++;
        if ({AWREADY, WREADY, ARREADY, BVALID, RVALID} !== 5'b0) begin
            errors++; $display("FAIL reset_ctrl: got %b, required 00000", {AWREADY, WREADY, ARREADY, BVALID, RVALID});
        end
        checks++;
        if ({BRESP, RRESP, RDATA} !== 36'h0) begin
            errors++; $display("FAIL reset_payload: got BRESP=%b RRESP=%b RDATA=%h, required zeros", BRESP, RRESP, RDATA);
        end
        ARESETN = 1;
        model_clear();
        @(negedge ACLK);
        checks++;
        if ({AWREADY, WREADY, ARREADY, BVALID, RVALID} !== 5'b11100) begin
            errors++; $display("FAIL reset_release: got %b, required 11100", {AWREADY, WREADY, ARREADY, BVALID, RVALID});
        end
    endtask

    task automatic test_basic();
        logic [1:0]  resp;
        logic [31:0] rd;
        int          lat;
        send_aw_w(32'h604, 32'hDEADBEEF, 4'hF, 0, 0);
        model_write(32'h604, 32'hDEADBEEF, 4'hF);
        wait_b(0, resp, lat);
        checks++;
        if (lat != 0 || resp !== 2'b00) begin
            errors++; $display("FAIL basic_b: got lat=%0d BRESP=%b, required lat=0 BRESP=00", lat, resp);
        end
        read_reg(32'h604, 0, rd, resp, lat);
        checks++;
        if (rd !== 32'hDEADBEEF || resp !== 2'b00 || lat != 0) begin
            errors++; $display("FAIL basic_read: got %h/%b lat=%0d, required deadbeef/00 lat=0", rd, resp, lat);
        end
        send_aw_w(32'h604, 32'h11223344, 4'h3, 0, 0);
        model_write(32'h604, 32'h11223344, 4'h3);
        wait_b(0, resp, lat);
        read_reg(32'h604, 0, rd, resp, lat);
        checks++;
        if (rd !== 32'hDEAD3344) begin
            errors++; $display("FAIL strobe_merge: got %h, required dead3344", rd);
        end
    endtask

    task automatic test_w_before_aw();
        logic [1:0]  resp;
        logic [31:0] rd;
        int          lat;
        @(negedge ACLK);
        AWADDR = 32'h608; WDATA = 32'h000000AA; WSTRB = 4'hF; WVALID = 1;
        for (int i = 0; i < 3; i++) begin
            @(negedge ACLK);
            WVALID = 0;
            checks++;
            if ({AWREADY, WREADY, BVALID} !== 3'b100) begin
                errors++; $display("FAIL w_first_ready c%0d: got AWREADY/WREADY/BVALID=%b, required 100", i, {AWREADY, WREADY, BVALID});
            end
        end
        AWVALID = 1;
        @(negedge ACLK);
        AWVALID = 0;
        checks++;
        if (BVALID !== 1'b1) begin
            errors++; $display("FAIL w_first_commit: got BVALID=%b, required 1", BVALID);
        end
        model_write(32'h608, 32'h000000AA, 4'hF);
        wait_b(0, resp, lat);
        read_reg(32'h608, 0, rd, resp, lat);
        checks++;
        if (rd !== 32'h000000AA) begin
            errors++; $display("FAIL w_first_read: got %h, required 000000aa", rd);
        end
    endtask

    task automatic test_backpressure();
        logic [31:0] addr;
        logic [31:0] data;
        logic [1:0]  resp;
        int          lat;
        addr = 32'h600 + ($urandom_range(0, 15) << 2);
        data = $urandom;
        send_aw_w(addr, data, 4'hF, 0, 0);
        model_write(addr, data, 4'hF);
        for (int i = 0; i < 5; i++) begin
            checks++;
            if ({BVALID, BRESP, AWREADY, WREADY} !== 5'b10000) begin
                errors++; $display("FAIL b_hold c%0d: got BVALID,BRESP,AWREADY,WREADY=%b, required 10000", i, {BVALID, BRESP, AWREADY, WREADY});
            end
            @(negedge ACLK);
        end
        wait_b(0, resp, lat);
        checks++;
        if ({AWREADY, WREADY, BVALID} !== 3'b110) begin
            errors++; $display("FAIL b_release: got AWREADY,WREADY,BVALID=%b, required 110", {AWREADY, WREADY, BVALID});
        end
        ARADDR = addr; ARVALID = 1;
        @(negedge ACLK);
        ARVALID = 0;
        for (int i = 0; i < 4; i++) begin
            checks++;
            if ({RVALID, RRESP, ARREADY} !== 4'b1000 || RDATA !== model[widx(addr)]) begin
                errors++; $display("FAIL r_hold c%0d: got RVALID,RRESP,ARREADY=%b RDATA=%h, required 1000 %h", i, {RVALID, RRESP, ARREADY}, RDATA, model[widx(addr)]);
            end
            @(negedge ACLK);
        end
        RREADY = 1;
        @(negedge ACLK);
        RREADY = 0;
        checks++;
        if ({RVALID, ARREADY} !== 2'b01) begin
            errors++; $display("FAIL r_release: got RVALID,ARREADY=%b, required 01", {RVALID, ARREADY});
        end
    endtask

    task automatic test_out_of_range();
        logic [31:0] oor [3];
        logic [31:0] rd;
        logic [1:0]  resp;
        int          lat;
        oor[0] = 32'h800; oor[1] = 32'h640; oor[2] = 32'h5FC;
        for (int i = 0; i < 3; i++) begin
            send_aw_w(oor[i], (i == 0) ? 32'h12345678 : $urandom, 4'hF, 0, 0);
            wait_b(0, resp, lat);
            checks++;
            if (resp !== EXP_OOR) begin
                errors++; $display("FAIL oor_bresp %h: got %b, required %b", oor[i], resp, EXP_OOR);
            end
            read_reg(oor[i], 0, rd, resp, lat);
            checks++;
            if (rd !== 32'h0 || resp !== EXP_OOR) begin
                errors++; $display("FAIL oor_read %h: got %h/%b, required 00000000/%b", oor[i], rd, resp, EXP_OOR);
            end
        end
        send_aw_w(32'h63F, 32'h0BADCAFE, 4'hF, 0, 0);
        model_write(32'h63F, 32'h0BADCAFE, 4'hF);
        wait_b(0, resp, lat);
        checks++;
        if (resp !== 2'b00) begin
            errors++; $display("FAIL top_edge_bresp: got %b, required 00", resp);
        end
        for (int i = 0; i < 16; i++) begin
            read_reg(32'h600 + 32'(i * 4), 0, rd, resp, lat);
            checks++;
            if (rd !== model[i] || resp !== 2'b00) begin
                errors++; $display("FAIL window_scan r%0d: got %h/%b, required %h/00", i, rd, resp, model[i]);
            end
        end
    endtask

    task automatic test_same_edge();
        logic [31:0] old_val;
        logic [31:0] new_val;
        logic [31:0] rd;
        logic [1:0]  resp;
        int          lat;
        old_val = model[4];
        new_val = $urandom;
        @(negedge ACLK);
        AWADDR = 32'h610; WDATA = new_val; WSTRB = 4'hF; ARADDR = 32'h610;
        AWVALID = 1; WVALID = 1; ARVALID = 1;
        @(negedge ACLK);
        AWVALID = 0; WVALID = 0; ARVALID = 0;
        checks++;
        if (RVALID !== 1'b1 || RDATA !== old_val || BVALID !== 1'b1) begin
            errors++; $display("FAIL same_edge: got RVALID=%b RDATA=%h BVALID=%b, required 1 %h 1", RVALID, RDATA, BVALID, old_val);
        end
        model_write(32'h610, new_val, 4'hF);
        BREADY = 1; RREADY = 1;
        @(negedge ACLK);
        BREADY = 0; RREADY = 0;
        read_reg(32'h610, 0, rd, resp, lat);
        checks++;
        if (rd !== new_val) begin
            errors++; $display("FAIL same_edge_after: got %h, required %h", rd, new_val);
        end
    endtask

    task automatic test_back_to_back();
        logic [31:0] a;
        logic [31:0] d;
        logic [3:0]  s;
        logic [31:0] rd;
        logic [1:0]  resp;
        int          lat;
        int          commits;
        bit          pending;
        commits = 0;
        @(negedge ACLK);
        a = 32'h600 + $urandom_range(0, 63); d = $urandom; s = 4'($urandom);
        AWADDR = a; WDATA = d; WSTRB = s; AWVALID = 1; WVALID = 1; BREADY = 1;
        pending = AWREADY && WREADY;
        for (int i = 0; i < 20; i++) begin
            @(negedge ACLK);
            if (pending) begin
                model_write(a, d, s);
                commits++;
                a = 32'h600 + $urandom_range(0, 63); d = $urandom; s = 4'($urandom);
                AWADDR = a; WDATA = d; WSTRB = s;
            end
            if (i == 19) begin
                AWVALID = 0; WVALID = 0; pending = 0;
            end else begin
                pending = AWREADY && WREADY;
            end
        end
        BREADY = 0;
        checks++;
        if (commits != 10 || BVALID !== 1'b0) begin
            errors++; $display("FAIL throughput: got %0d commits BVALID=%b, required 10 commits BVALID=0", commits, BVALID);
        end
        for (int i = 0; i < 16; i++) begin
            read_reg(32'h600 + 32'(i * 4), 0, rd, resp, lat);
            checks++;
            if (rd !== model[i]) begin
                errors++; $display("FAIL b2b_scan r%0d: got %h, required %h", i, rd, model[i]);
            end
        end
    endtask

    task automatic test_random();
        logic [31:0] a;
        logic [31:0] d;
        logic [3:0]  s;
        logic [31:0] rd;
        logic [1:0]  resp;
        int          lat;
        for (int n = 0; n < 60; n++) begin
            a = rand_addr();
            if ($urandom_range(0, 1) == 1) begin
                d = $urandom; s = 4'($urandom);
                send_aw_w(a, d, s, $urandom_range(0, 3), $urandom_range(0, 3));
                model_write(a, d, s);
                wait_b($urandom_range(0, 3), resp, lat);
                checks++;
                if (resp !== exp_resp(a) || lat != 0) begin
                    errors++; $display("FAIL rand_write %0d @%h: got %b lat=%0d, required %b lat=0", n, a, resp, lat, exp_resp(a));
                end
            end else begin
                read_reg(a, $urandom_range(0, 3), rd, resp, lat);
                checks++;
                if (rd !== model_read(a) || resp !== exp_resp(a) || lat != 0) begin
                    errors++; $display("FAIL rand_read %0d @%h: got %h/%b lat=%0d, required %h/%b lat=0", n, a, rd, resp, lat, model_read(a), exp_resp(a));
                end
            end
        end
    endtask

    task automatic test_reset_mid();
        logic [31:0] rd;
        logic [1:0]  resp;
        int          lat;
        send_aw_w(32'h600, 32'hCAFEF00D, 4'hF, 0, 0);
        model_write(32'h600, 32'hCAFEF00D, 4'hF);
        wait_b(0, resp, lat);
        @(negedge ACLK);
        ARADDR = 32'h600; ARVALID = 1;
        AWADDR = 32'h604; WDATA = 32'hFFFFFFFF; WSTRB = 4'hF; WVALID = 1;
        @(negedge ACLK);
        ARVALID = 0; WVALID = 0;
        checks++;
        if (RVALID !== 1'b1 || RDATA !== 32'hCAFEF00D || WREADY !== 1'b0) begin
            errors++; $display("FAIL pre_reset: got RVALID=%b RDATA=%h WREADY=%b, required 1 cafef00d 0", RVALID, RDATA, WREADY);
        end
        ARESETN = 0;
        @(negedge ACLK);
        checks++;
        if ({RVALID, BVALID, AWREADY, WREADY, ARREADY} !== 5'b0 || RDATA !== 32'h0) begin
            errors++; $display("FAIL mid_reset: got ctrl=%b RDATA=%h, required 00000 00000000", {RVALID, BVALID, AWREADY, WREADY, ARREADY}, RDATA);
        end
        ARESETN = 1;
        model_clear();
        @(negedge ACLK);
        AWADDR = 32'h604; AWVALID = 1;
        @(negedge ACLK);
        AWVALID = 0;
        repeat (2) @(negedge ACLK);
        checks++;
        if ({BVALID, AWREADY, WREADY} !== 3'b001) begin
            errors++; $display("FAIL stale_w_dropped: got BVALID,AWREADY,WREADY=%b, required 001", {BVALID, AWREADY, WREADY});
        end
        WDATA = 32'h55555555; WSTRB = 4'h0; WVALID = 1;
        @(negedge ACLK);
        WVALID = 0;
        wait_b(0, resp, lat);
        checks++;
        if (resp !== 2'b00 || lat != 0) begin
            errors++; $display("FAIL zero_strb_b: got %b lat=%0d, required 00 lat=0", resp, lat);
        end
        read_reg(32'h600, 0, rd, resp, lat);
        checks++;
        if (rd !== 32'h0) begin
            errors++; $display("FAIL post_reset_600: got %h, required 00000000", rd);
        end
        read_reg(32'h604, 0, rd, resp, lat);
        checks++;
        if (rd !== 32'h0) begin
            errors++; $display("FAIL post_reset_604: got %h, required 00000000", rd);
        end
    endtask

    initial begin
        ARESETN = 0;
        AWADDR = 0; AWPROT = 0; AWVALID = 0;
        WDATA = 0; WSTRB = 0; WVALID = 0; BREADY = 0;
        ARADDR = 0; ARPROT = 0; ARVALID = 0; RREADY = 0;
        model_clear();
        test_reset();
        test_basic();
        test_w_before_aw();
        test_backpressure();
        test_out_of_range();
        test_same_edge();
        test_back_to_back();
        test_random();
        test_reset_mid();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: got simulation time limit, required completion");
        $fatal(1, "watchdog expired");
    end

endmodule
